sha3_result_drain: RTL and testbench
====================================

Name: sha3_result_drain

Overview:
- Downstream of the SHA3 scanner. Captures every candidate the scanner reports, meaning each one-cycle capture pulse with its nonce and 25x64 hash.
- Holds candidates in a small FIFO and serializes each one as 32-bit words on a valid/ready stream toward the AXI register/DMA front end.
- Prevents back-to-back finds from overwriting each other in the scanner's single result register.
- Reports overflow and whole-scan drain status.

Parameters:
- DEPTH, 4: number of candidate entries held (power of two, 2..16).
- CNT_W, 16: width of the saturating overflow counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of FIFO, serializer and counters.
- capture  in  1  one-cycle candidate pulse from scanner; may be high on consecutive cycles.
- nonce  in  32  candidate nonce, valid with capture.
- hash  in  64x25  candidate state words 0..24, valid with capture.
- awaiting  in  1  scanner still expects results.
- m_data  out  32  serialized word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts word.
- m_last  out  1  final word of current candidate.
- count  out  $clog2(DEPTH)+1  entries stored, including the one being serialized.
- full  out  1  count == DEPTH.
- overflow_count  out  CNT_W  candidates dropped; saturates at all-ones.
- drained  out  1  scan finished and nothing left to read.

Behaviour:
- Reset or clear:
  - count=0, write/read pointers=0, word index=0, m_valid=0, m_last=0, m_data=0, overflow_count=0, full=0, drained=1.
  - clear has priority over capture and handshake in the same cycle.
- Write:
  - capture while count<DEPTH stores {nonce, hash} at the write pointer; the pointer wraps modulo DEPTH.
  - capture while count==DEPTH drops the candidate and increments overflow_count, saturating.
  - Fullness is evaluated before any same-cycle pop. A capture that arrives in the cycle the head entry completes is still dropped when full.
- Latency: capture at edge N into an empty FIFO gives m_valid=1 with word 0 after edge N+1 (one registered stage).
- Word order per entry, 51 words, index w=0..50:
  - w0 = nonce.
  - w(2k+1) = hash[k][31:0].
  - w(2k+2) = hash[k][63:32], for k=0..24.
  - m_last=1 only at w50.
- Handshake:
  - A word transfers when m_valid & m_ready.
  - m_data and m_last hold stable while m_valid & ~m_ready.
  - m_valid never drops without a transfer, except on rst/clear.
- Serializer states:
  - IDLE (m_valid=0): moves to SEND when count>0.
  - SEND: word index increments on each transfer.
  - On transfer of w50: index returns to 0, read pointer advances, count decrements (net 0 if a write lands the same cycle).
  - After w50, goes to the next entry with no bubble if count stays >0 after the update, otherwise to IDLE.
- count: updated as +1 on an accepted write, -1 on entry completion, unchanged if both occur in the same cycle.
- drained: registered; equals ~awaiting & (count==0) & ~m_valid, evaluated each cycle.
- Stored entries are never modified after write.
- Capture of identical nonces is not filtered.

Test Plan:
- Single capture with nonce=0x0000_1234 and hash[k]={32'hA000_0000+k, 32'h5000_0000+k}, m_ready=1 -> m_valid rises 1 cycle later. Words are 0x1234, 0x5000_0000, 0xA000_0000, ..., 0x5000_0018, 0xA000_0018. m_last only on word 50. count returns to 0.
- Five captures on consecutive cycles, DEPTH=4, m_ready=0 -> full=1 after 4 captures, fifth dropped, overflow_count=1. Releasing m_ready then yields exactly 4 entries (204 words) in capture order.
- m_ready toggled randomly during an entry -> m_data and m_last never change while stalled; no words lost or duplicated.
- Capture in the same cycle as w50 transfer with count=1 -> entry accepted, count stays 1, next entry's w0 presented with no bubble.
- clear asserted mid-entry together with capture -> next cycle m_valid=0, count=0, overflow_count=0. The concurrent capture is discarded.
- awaiting high with count=0 -> drained=0. Awaiting falls while one entry is pending -> drained stays 0 until w50 transfers, then drained=1 the following cycle.

Source files
------------

// File: rtl/sha3_result_drain.sv
// rtl/sha3_result_drain.sv - candidate capture FIFO and 32-bit word serializer for SHA3 scan results
//
// Purpose: buffers scanner candidates ({nonce, 25x64 hash}) in a DEPTH-entry FIFO
// and streams each one as 51 words on a valid/ready interface.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous flush of FIFO, serializer and counters
//   capture         one-cycle candidate pulse; nonce/hash valid with it
//   awaiting        scanner still expects results (feeds drained)
//   m_data/m_valid/m_ready/m_last  word stream toward the register/DMA front end
//   count, full     FIFO occupancy including the entry being serialized
//   overflow_count  saturating count of candidates dropped while full
//   drained         scan finished and nothing left to read
module sha3_result_drain #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     capture,
  input  logic [31:0]              nonce,
  input  logic [24:0][63:0]        hash,
  input  logic                     awaiting,
  output logic [31:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [CNT_W-1:0]         overflow_count,
  output logic                     drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 32 + 25 * 64;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [5:0] LAST_W = 6'd50;

  typedef enum logic {S_IDLE, S_SEND} state_e;

  // Entry layout puts the nonce in the low word and hash[k] right above it, so
  // word w of the stream is simply bits [32*w +: 32] of the stored entry.
  logic [EW-1:0]    mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [5:0]       idx_q, idx_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             drained_q;
  logic             wr_en, xfer, done;

  always_comb begin
    // Fullness uses the pre-pop count: a capture in the completion cycle of a
    // full FIFO is dropped.
    wr_en   = capture & (count_q != DEPTH_C);
    xfer    = (state_q == S_SEND) & m_ready;
    done    = xfer & (idx_q == LAST_W);

    count_d = count_q;
    if (wr_en & ~done) begin
      count_d = count_q + 1'b1;
    end else if (~wr_en & done) begin
      count_d = count_q - 1'b1;
    end

    wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = done  ? rptr_q + 1'b1 : rptr_q;

    idx_d   = idx_q;
    if (xfer) begin
      idx_d = done ? 6'd0 : idx_q + 6'd1;
    end

    ovf_d   = ovf_q;
    if (capture & ~wr_en & ~&ovf_q) begin
      ovf_d = ovf_q + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_SEND;
      // Stay in SEND across entries so the next w0 follows w50 with no bubble.
      S_SEND: if (done && count_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      ovf_q     <= '0;
      drained_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      drained_q <= ~awaiting & (count_q == '0) & (state_q == S_IDLE);
    end
  end

  // Storage is not reset; entries are only visible through count/rptr.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !clear) begin
      mem_q[wptr_q] <= {hash, nonce};
    end
  end

  assign m_valid        = (state_q == S_SEND);
  // Gating with m_valid keeps m_data at zero while idle or after reset.
  assign m_data         = m_valid ? mem_q[rptr_q][{idx_q, 5'b0} +: 32] : 32'd0;
  assign m_last         = m_valid & (idx_q == LAST_W);
  assign count          = count_q;
  assign full           = (count_q == DEPTH_C);
  assign overflow_count = ovf_q;
  assign drained        = drained_q;

endmodule

// File: tb/tb_sha3_result_drain.sv
// tb/tb_sha3_result_drain.sv - self-checking bench for sha3_result_drain
module tb_sha3_result_drain;

  logic              clk = 1'b0;
  logic              rst, clear, capture, awaiting, m_ready;
  logic [31:0]       nonce;
  logic [24:0][63:0] hash;
  logic [31:0]       m_data;
  logic              m_valid, m_last, full, drained;
  logic [2:0]        count;
  logic [15:0]       overflow_count;

  int total = 0;
  int pass_cnt = 0;

  logic [31:0] sb_nonce[$];
  logic [31:0] sb_base[$];
  int          wi = 0;

  sha3_result_drain #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .capture(capture), .nonce(nonce),
    .hash(hash), .awaiting(awaiting), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .count(count), .full(full),
    .overflow_count(overflow_count), .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cap;
    logic [31:0] n;
    logic        acc;
    logic [31:0] e_data;
    logic        e_valid;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic [15:0] e_ovf;
    logic        e_drn;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] expw(input logic [31:0] n, input logic [31:0] base, input int w);
    int k;
    if (w == 0) return n;
    k = (w - 1) / 2;
    if (((w - 1) % 2) == 0) return 32'h5000_0000 + base + k;
    return 32'hA000_0000 + base + k;
  endfunction

  task automatic set_cap(input logic [31:0] n, input logic [31:0] base);
    capture = 1'b1;
    nonce   = n;
    for (int k = 0; k < 25; k++) begin
      hash[k] = {32'hA000_0000 + base + k, 32'h5000_0000 + base + k};
    end
  endtask

  // Consumes n words, checking each against the scoreboard and checking that
  // stalled words hold stable. Called at #1 after an edge; returns likewise.
  task automatic drain(input int n, input bit rnd);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] sd;
    logic sl;
    while (got < n && cyc < 5000) begin
      if (stalled) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", m_data, sd);
        chk("stall_last", {31'd0, m_last}, {31'd0, sl});
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        if (sb_nonce.size() == 0) begin
          chk("unexpected_word", m_data, 32'hDEAD_BEEF);
        end else begin
          chk("word", m_data, expw(sb_nonce[0], sb_base[0], wi));
          chk("last", {31'd0, m_last}, (wi == 50) ? 32'd1 : 32'd0);
          if (wi == 50) begin
            wi = 0;
            void'(sb_nonce.pop_front());
            void'(sb_base.pop_front());
          end else begin
            wi++;
          end
        end
        got++;
        stalled = 0;
      end else if (m_valid) begin
        stalled = 1;
        sd = m_data;
        sl = m_last;
      end else begin
        stalled = 0;
      end
      tick();
      cyc++;
    end
    if (cyc >= 5000) chk("drain_timeout", got, n);
    m_ready = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 32'h11, 1'b1, 32'h0,  1'b0, 3'd1, 1'b0, 16'd0, 1'b0};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 32'h11, 1'b1, 3'd2, 1'b0, 16'd0, 1'b0};
    tbl[2] = '{1'b1, 32'h33, 1'b1, 32'h11, 1'b1, 3'd3, 1'b0, 16'd0, 1'b0};
    tbl[3] = '{1'b1, 32'h44, 1'b1, 32'h11, 1'b1, 3'd4, 1'b1, 16'd0, 1'b0};
    tbl[4] = '{1'b1, 32'h55, 1'b0, 32'h11, 1'b1, 3'd4, 1'b1, 16'd1, 1'b0};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 32'h11, 1'b1, 3'd4, 1'b1, 16'd1, 1'b0};

    rst = 1'b1; clear = 1'b0; capture = 1'b0; awaiting = 1'b0; m_ready = 1'b0;
    nonce = '0; hash = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {16'd0, overflow_count}, 32'd0);
    chk("rst_drained", {31'd0, drained}, 32'd1);

    // Single capture, one-cycle latency, full 51-word entry.
    m_ready = 1'b1;
    set_cap(32'h0000_1234, 32'h0);
    sb_nonce.push_back(32'h1234); sb_base.push_back(32'h0);
    tick();
    capture = 1'b0;
    chk("t1_count1", {29'd0, count}, 32'd1);
    chk("t1_valid_early", {31'd0, m_valid}, 32'd0);
    tick();
    chk("t1_latency_valid", {31'd0, m_valid}, 32'd1);
    chk("t1_latency_w0", m_data, 32'h1234);
    drain(51, 0);
    chk("t1_count0", {29'd0, count}, 32'd0);
    chk("t1_idle", {31'd0, m_valid}, 32'd0);
    tick();
    chk("t1_drained", {31'd0, drained}, 32'd1);

    // Five back-to-back captures into a depth-4 FIFO with the consumer stalled.
    awaiting = 1'b1;
    m_ready  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].cap) set_cap(tbl[i].n, tbl[i].n << 8);
      else capture = 1'b0;
      if (tbl[i].acc) begin
        sb_nonce.push_back(tbl[i].n); sb_base.push_back(tbl[i].n << 8);
      end
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_data", i), m_data, tbl[i].e_data);
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, tbl[i].e_cnt});
      chk($sformatf("v%0d_full", i), {31'd0, full}, {31'd0, tbl[i].e_full});
      chk($sformatf("v%0d_ovf", i), {16'd0, overflow_count}, {16'd0, tbl[i].e_ovf});
      chk($sformatf("v%0d_drained", i), {31'd0, drained}, {31'd0, tbl[i].e_drn});
    end
    capture = 1'b0;
    drain(204, 1);
    chk("t2_count0", {29'd0, count}, 32'd0);
    chk("t2_sb_empty", sb_nonce.size(), 32'd0);

    // Capture in the same cycle as w50 with a single entry stored.
    set_cap(32'h77, 32'h7700);
    sb_nonce.push_back(32'h77); sb_base.push_back(32'h7700);
    tick();
    capture = 1'b0;
    drain(50, 0);
    m_ready = 1'b1;
    chk("t4_last", {31'd0, m_last}, 32'd1);
    chk("t4_w50", m_data, expw(32'h77, 32'h7700, 50));
    void'(sb_nonce.pop_front()); void'(sb_base.pop_front());
    wi = 0;
    set_cap(32'h88, 32'h8800);
    sb_nonce.push_back(32'h88); sb_base.push_back(32'h8800);
    tick();
    capture = 1'b0;
    chk("t4_count", {29'd0, count}, 32'd1);
    chk("t4_nobubble_valid", {31'd0, m_valid}, 32'd1);
    chk("t4_nobubble_w0", m_data, 32'h88);
    drain(51, 0);
    chk("t4_count0", {29'd0, count}, 32'd0);

    // Clear mid-entry together with a capture.
    set_cap(32'h99, 32'h9900);
    sb_nonce.push_back(32'h99); sb_base.push_back(32'h9900);
    tick();
    capture = 1'b0;
    drain(10, 0);
    chk("t5_ovf_before", {16'd0, overflow_count}, 32'd1);
    clear = 1'b1;
    set_cap(32'hAA, 32'hAA00);
    tick();
    clear = 1'b0; capture = 1'b0;
    sb_nonce.delete(); sb_base.delete(); wi = 0;
    chk("t5_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_count", {29'd0, count}, 32'd0);
    chk("t5_ovf", {16'd0, overflow_count}, 32'd0);
    chk("t5_data", m_data, 32'd0);
    tick();
    chk("t5_discard_count", {29'd0, count}, 32'd0);
    chk("t5_discard_valid", {31'd0, m_valid}, 32'd0);

    // drained follows awaiting and the last transfer.
    awaiting = 1'b1;
    tick(); tick();
    chk("t6_await_drained", {31'd0, drained}, 32'd0);
    set_cap(32'hBB, 32'hBB00);
    sb_nonce.push_back(32'hBB); sb_base.push_back(32'hBB00);
    tick();
    capture = 1'b0; awaiting = 1'b0;
    tick();
    chk("t6_pending_drained", {31'd0, drained}, 32'd0);
    drain(51, 0);
    chk("t6_after_w50", {31'd0, drained}, 32'd0);
    tick();
    chk("t6_drained", {31'd0, drained}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
